// File: rtl/dmem_sram.sv
// Word-organised data memory behind a valid/ready request port.
// Each request completes after a programmable latency with a one-cycle response pulse.
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// BUSY  | request captured; counting down to the access edge
// RESP  | resp_valid=1 for this single cycle
module dmem_sram #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [31:0] SPAN     = 32'd4 << DEPTH_LOG2;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    cap_wen;
  logic [31:0]             cap_addr;
  logic [31:0]             cap_wdata;
  logic [3:0]              cap_wmask;
  logic [31:0]             off;
  logic                    in_range;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [31:0]             mask32;
  logic                    access;
  logic                    accept;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Wrap-around subtraction folds "below base" into the out-of-range compare.
  assign off      = cap_addr - BASE_ADDR;
  assign in_range = off < SPAN;
  assign idx      = off[DEPTH_LOG2+1:2];
  assign mask32   = {{8{cap_wmask[3]}}, {8{cap_wmask[2]}},
                     {8{cap_wmask[1]}}, {8{cap_wmask[0]}}};

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = (state == IDLE) && req_valid;
  assign access     = (state == BUSY) && (cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_wen   <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_wmask <= 4'd0;
    end else if (accept) begin
      cap_wen   <= req_wen;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_wmask <= req_wmask;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (access) begin
      resp_err   <= !in_range;
      resp_rdata <= (in_range && !cap_wen) ? mem[idx] : 32'd0;
    end
  end

  // Array has no reset; while rst is low the FSM sits in IDLE so no write fires.
  always_ff @(posedge clk) begin
    if (access && cap_wen && in_range) begin
      mem[idx] <= (cap_wdata & mask32) | (mem[idx] & ~mask32);
    end
  end

endmodule

// File: tb/tb_dmem_sram.sv
// Bench for dmem_sram: three instances (latency 1, 4, 3) driven with directed and
// random requests; a monitor checks every response against a queue of expectations.
module tb_dmem_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          NW   = 1024;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i  [3];
  logic        valid  [3];
  logic        ready  [3];
  logic        wen    [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [3:0]  wmask  [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic        rerr   [3];

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  run = 0;
  int  acc_cyc [3];
  bit  has_acc [3];
  exp_t sb_q [3][$];
  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_sram #(
      .DEPTH_LOG2(10),
      .BASE_ADDR (32'h8000_0000),
      .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 4 : 3))
    ) u_dut (
      .clk       (clk),
      .rst       (rst_i[g]),
      .req_valid (valid[g]),
      .req_ready (ready[g]),
      .req_wen   (wen[g]),
      .req_addr  (addr[g]),
      .req_wdata (wdata[g]),
      .req_wmask (wmask[g]),
      .resp_valid(rvalid[g]),
      .resp_rdata(rdata[g]),
      .resp_err  (rerr[g])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 3);
  endfunction

  // Monitor: response checking and req_ready timing, decoupled from the driver.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_rdy;
    if (run) begin
      for (int i = 0; i < 3; i++) begin
        if (rst_i[i]) begin
          exp_rdy = !(has_acc[i] && cyc <= acc_cyc[i] + lat_of(i));
          checks++;
          if (ready[i] !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready inst%0d cyc %0d: got %b want %b", i, cyc, ready[i], exp_rdy);
          end
        end
        if (rvalid[i] !== 1'b0) begin
          checks++;
          if (sb_q[i].size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp inst%0d cyc %0d: resp_valid=%b want 0", i, cyc, rvalid[i]);
          end else begin
            e = sb_q[i].pop_front();
            if (rdata[i] !== e.rdata || rerr[i] !== e.err || cyc != e.cyc) begin
              errors++;
              $display("FAIL resp inst%0d: got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                       i, rdata[i], rerr[i], cyc, e.rdata, e.err, e.cyc);
            end
          end
        end
      end
    end
  end

  // Reference model: byte-addressed view of a word array, per instance.
  function automatic exp_t model(input int i, input bit w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] m);
    exp_t        e;
    logic [31:0] off;
    int          key;
    logic [31:0] word;
    off     = a - BASE;
    e.rdata = 32'd0;
    e.err   = 1'b0;
    e.cyc   = 0;
    if (off >= 32'(4 * NW)) begin
      e.err = 1'b1;
    end else begin
      key  = i * NW + int'(off / 4);
      word = ref_mem.exists(key) ? ref_mem[key] : 32'hxxxx_xxxx;
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (m[b]) word[8*b +: 8] = d[8*b +: 8];
        end
        ref_mem[key] = word;
      end else begin
        e.rdata = word;
      end
    end
    return e;
  endfunction

  task automatic issue(input int i, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m, input bit complete);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (ready[i] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready[i] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout inst%0d: req_ready=%b want 1", i, ready[i]);
      return;
    end
    valid[i] = 1'b1;
    wen[i]   = w;
    addr[i]  = a;
    wdata[i] = d;
    wmask[i] = m;
    @(posedge clk);
    #1;
    acc_cyc[i] = cyc;
    has_acc[i] = 1'b1;
    // Scramble request inputs while the access is pending.
    valid[i] = 1'b0;
    wen[i]   = 1'($urandom);
    addr[i]  = $urandom;
    wdata[i] = $urandom;
    wmask[i] = 4'($urandom);
    if (complete) begin
      e     = model(i, w, a, d, m);
      e.cyc = acc_cyc[i] + lat_of(i);
      sb_q[i].push_back(e);
      n = 0;
      while (sb_q[i].size() != 0 && n < lat_of(i) + 10) begin
        @(negedge clk);
        n++;
      end
      if (sb_q[i].size() != 0) begin
        checks++;
        errors++;
        $display("FAIL resp_timeout inst%0d: %0d responses outstanding want 0", i, sb_q[i].size());
        sb_q[i].delete();
      end
    end
  endtask

  task automatic check_idle(input int i, input string tag);
    checks++;
    if (ready[i] !== 1'b1 || rvalid[i] !== 1'b0 || rdata[i] !== 32'd0 || rerr[i] !== 1'b0) begin
      errors++;
      $display("FAIL %s inst%0d: ready=%b valid=%b rdata=%h err=%b want 1 0 00000000 0",
               tag, i, ready[i], rvalid[i], rdata[i], rerr[i]);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 19);
    if (k == 16) return BASE + 32'h0000_0FFC;
    if (k == 17) return BASE - 32'(4 * $urandom_range(1, 64));
    if (k >= 18) return BASE + 32'h0000_1000 + ($urandom & 32'h000F_FFFF);
    return BASE + 32'(4 * k) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_i[i] = 1'b0; valid[i] = 1'b0; wen[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0; wmask[i] = '0;
      has_acc[i] = 1'b0; acc_cyc[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle(i, "reset_state");
    for (int i = 0; i < 3; i++) rst_i[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle(i, "after_reset");
    run = 1'b1;

    // Preload every word the random phase can read.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 16; k++) issue(i, 1'b1, BASE + 32'(4 * k), $urandom, 4'hF, 1'b1);
      issue(i, 1'b1, BASE + 32'h0FFC, $urandom, 4'hF, 1'b1);
    end

    // Full store then load, latency 1.
    issue(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
    issue(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 1'b1);
    // Partial store.
    issue(0, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 1'b1);
    issue(0, 1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 1'b1);
    issue(0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 1'b1);
    issue(0, 1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 1'b1);
    issue(0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 1'b1);
    // Out of range, then the edge words are untouched.
    issue(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 1'b1);
    issue(0, 1'b1, 32'h8000_1000, 32'hCAFE_F00D, 4'hF, 1'b1);
    issue(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 1'b1);
    issue(0, 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 1'b1);
    // Unaligned load.
    issue(0, 1'b0, 32'h8000_0013, 32'h0, 4'h0, 1'b1);
    // Latency 4 load with the address changing while busy.
    issue(1, 1'b0, 32'h8000_0008, 32'h0, 4'h0, 1'b1);

    // Reset during BUSY drops the pending store.
    issue(2, 1'b1, 32'h8000_0040, 32'h0000_0000, 4'hF, 1'b1);
    issue(2, 1'b1, 32'h8000_0040, 32'h5555_5555, 4'hF, 1'b0);
    @(posedge clk);
    #2;
    rst_i[2]   = 1'b0;
    has_acc[2] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_i[2] = 1'b1;
    @(negedge clk);
    check_idle(2, "after_midop_reset");
    issue(2, 1'b0, 32'h8000_0040, 32'h0, 4'h0, 1'b1);

    // Random traffic on every instance.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 3; i++) begin
        issue(i, 1'($urandom), rand_addr(), $urandom, 4'($urandom), 1'b1);
      end
    end

    repeat (8) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
